// File: rtl/csr_pkg.sv
// ============================================================
// csr_pkg : shared CSR addresses, op codes, field indices, causes
// Rev 1.0
// ============================================================
`default_nettype none

package csr_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12
    } csr_addr_t;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;

    localparam logic [31:0] MSTATUS_MPP_M    = 32'h0000_1800;
    localparam logic [31:0] CAUSE_MTI        = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;

    function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old_val,
                                              input logic [31:0] src);
        case (op)
            CSR_OP_RS: csr_apply = old_val | src;
            CSR_OP_RC: csr_apply = old_val & ~src;
            default:   csr_apply = src;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================
// csr_counter64 : 64-bit counter, CSR writes replace one half
// Rev 1.0
// ============================================================
`default_nettype none

module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] r_value;
    logic [63:0] w_next;

    // The unwritten half keeps the full 64-bit increment, carry included.
    assign w_next = r_value + {63'b0, inc};
    assign value  = r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else begin
            r_value[31:0]  <= wr_lo ? wdata : w_next[31:0];
            r_value[63:32] <= wr_hi ? wdata : w_next[63:32];
        end
    end

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================
// csr_unit : M-mode CSR file, Zicsr ops, trap/irq/mret redirect
// Rev 1.0
// ============================================================
`default_nettype none

module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MTVEC_RESET  = 32'h8000_0000,
    parameter logic [31:0] MARCHID      = 32'h0,
    parameter int          HAS_COUNTERS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wsrc,
    input  logic            src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    input  logic            retire,
    input  logic [XLEN-1:0] next_pc,
    input  logic            irq_timer,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc
);

    if (XLEN != 32) begin : g_xlen_check
        $error("csr_unit supports XLEN=32 only");
    end

    localparam logic [31:0] c_EPC_MASK = 32'hFFFF_FFFC;

    logic        r_mie;
    logic        r_mpie;
    logic        r_mtie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;

    csr_op_t     w_op;
    logic [31:0] w_rdata;
    logic        w_known;
    logic        w_ro;
    logic        w_wr_req;
    logic        w_irq_take;
    logic        w_csr_wr;
    logic [31:0] w_wdata;
    logic [31:0] w_base;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;

    assign w_op = csr_op_t'(csr_op);

    always_comb begin
        w_rdata = '0;
        w_known = 1'b1;
        w_ro    = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:   w_rdata = MSTATUS_MPP_M | ({31'b0, r_mie} << MSTATUS_MIE)
                                                   | ({31'b0, r_mpie} << MSTATUS_MPIE);
            CSR_MIE:       w_rdata = {31'b0, r_mtie} << MIE_MTIE;
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MIP: begin
                w_rdata = {31'b0, irq_timer} << MIE_MTIE;
                w_ro    = 1'b1;
            end
            CSR_MCYCLE: begin
                w_rdata = w_mcycle[31:0];
                w_ro    = (HAS_COUNTERS == 0);
            end
            CSR_MCYCLEH: begin
                w_rdata = w_mcycle[63:32];
                w_ro    = (HAS_COUNTERS == 0);
            end
            CSR_MINSTRET: begin
                w_rdata = w_minstret[31:0];
                w_ro    = (HAS_COUNTERS == 0);
            end
            CSR_MINSTRETH: begin
                w_rdata = w_minstret[63:32];
                w_ro    = (HAS_COUNTERS == 0);
            end
            CSR_MVENDORID: w_rdata = '0;
            CSR_MARCHID:   w_rdata = MARCHID;
            default:       w_known = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads, so they are legal on read-only CSRs.
    assign w_wr_req   = (w_op == CSR_OP_RW) |
                        (((w_op == CSR_OP_RS) | (w_op == CSR_OP_RC)) & ~src_zero);
    assign illegal    = csr_en & (~w_known | (w_op == CSR_OP_RSVD) |
                        (w_wr_req & ((csr_addr[11:10] == 2'b11) | w_ro)));
    assign w_irq_take = retire & r_mie & r_mtie & irq_timer & ~trap_req;
    assign w_csr_wr   = csr_en & ~illegal & w_wr_req & ~trap_req & ~w_irq_take & ~mret;
    assign w_wdata    = csr_apply(w_op, w_rdata, csr_wsrc);
    assign w_base     = {r_mtvec[31:2], 2'b00};
    assign csr_rdata  = w_rdata;

    always_comb begin
        redirect_en = trap_req | w_irq_take | mret;
        redirect_pc = r_mepc;
        if (trap_req) begin
            redirect_pc = w_base;
        end else if (w_irq_take) begin
            redirect_pc = (r_mtvec[1:0] == 2'b01) ? w_base + 32'd28 : w_base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (trap_req) begin
            r_mepc   <= trap_pc & c_EPC_MASK;
            r_mcause <= trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_irq_take) begin
            r_mepc   <= next_pc & c_EPC_MASK;
            r_mcause <= CAUSE_MTI;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= w_wdata[MSTATUS_MIE];
                    r_mpie <= w_wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      r_mtie     <= w_wdata[MIE_MTIE];
                // Reserved vector modes 2/3 fall back to direct mode.
                CSR_MTVEC:    r_mtvec    <= {w_wdata[31:2], w_wdata[1] ? 2'b00 : w_wdata[1:0]};
                CSR_MSCRATCH: r_mscratch <= w_wdata;
                CSR_MEPC:     r_mepc     <= w_wdata & c_EPC_MASK;
                CSR_MCAUSE:   r_mcause   <= w_wdata;
                default: ;
            endcase
        end
    end

    if (HAS_COUNTERS != 0) begin : g_counters
        csr_counter64 u_mcycle (
            .clk   (clk),
            .reset (reset),
            .inc   (1'b1),
            .wr_lo (w_csr_wr && (csr_addr == CSR_MCYCLE)),
            .wr_hi (w_csr_wr && (csr_addr == CSR_MCYCLEH)),
            .wdata (w_wdata),
            .value (w_mcycle)
        );
        csr_counter64 u_minstret (
            .clk   (clk),
            .reset (reset),
            .inc   (retire & ~trap_req),
            .wr_lo (w_csr_wr && (csr_addr == CSR_MINSTRET)),
            .wr_hi (w_csr_wr && (csr_addr == CSR_MINSTRETH)),
            .wdata (w_wdata),
            .value (w_minstret)
        );
    end else begin : g_no_counters
        assign w_mcycle   = '0;
        assign w_minstret = '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================
// tb_csr_unit : directed + random bench with a behavioural CSR model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_csr_unit;

    localparam logic [31:0] C_MTVEC_RESET = 32'h8000_0000;
    localparam logic [31:0] C_MARCHID     = 32'h5A5A_0012;

    logic        clk = 1'b0;
    logic        reset, csr_en, src_zero, trap_req, mret, retire, irq_timer;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wsrc, trap_cause, trap_pc, next_pc;
    logic [31:0] csr_rdata, redirect_pc;
    logic        illegal, redirect_en;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    csr_unit #(
        .XLEN(32), .MTVEC_RESET(C_MTVEC_RESET), .MARCHID(C_MARCHID), .HAS_COUNTERS(1)
    ) dut (
        .clk(clk), .reset(reset), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wsrc(csr_wsrc), .src_zero(src_zero), .csr_rdata(csr_rdata), .illegal(illegal),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
        .retire(retire), .next_pc(next_pc), .irq_timer(irq_timer),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc)
    );

    // Architectural view of the CSRs as software would see them.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit known);
        known = 1'b1;
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return irq_timer ? 32'h80 : 32'h0;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            12'hF11: return 32'h0;
            12'hF12: return C_MARCHID;
            default: begin
                known = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    function automatic bit m_writes();
        return (csr_op == 2'd1) || ((csr_op >= 2'd2) && !src_zero);
    endfunction

    function automatic bit m_illegal();
        bit kn;
        logic [31:0] unused_v;
        unused_v = m_read(csr_addr, kn);
        if (!csr_en) return 1'b0;
        if (!kn || csr_op == 2'd0) return 1'b1;
        return m_writes() && (csr_addr >= 12'hC00 || csr_addr == 12'h344);
    endfunction

    function automatic bit m_irq();
        return retire && m_mstatus[3] && m_mie[7] && irq_timer && !trap_req;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [63:0] cn, ins;
        logic [31:0] old, nv;
        bit kn;
        if (reset) begin
            m_mstatus = 32'h1800; m_mie = 0; m_mtvec = C_MTVEC_RESET;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
        end else begin
            cn  = m_cycle + 64'd1;
            ins = m_instret + ((retire && !trap_req) ? 64'd1 : 64'd0);
            old = m_read(csr_addr, kn);
            if (trap_req) begin
                m_mepc = trap_pc & ~32'h3;
                m_mcause = trap_cause;
                m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            end else if (m_irq()) begin
                m_mepc = next_pc & ~32'h3;
                m_mcause = 32'h8000_0007;
                m_mstatus = 32'h1880;
            end else if (mret) begin
                m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (csr_en && !m_illegal() && m_writes()) begin
                case (csr_op)
                    2'd1:    nv = csr_wsrc;
                    2'd2:    nv = old | csr_wsrc;
                    default: nv = old & ~csr_wsrc;
                endcase
                case (csr_addr)
                    12'h300: m_mstatus = 32'h1800 | (nv & 32'h88);
                    12'h304: m_mie = nv & 32'h80;
                    12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'hB00: cn[31:0] = nv;
                    12'hB80: cn[63:32] = nv;
                    12'hB02: ins[31:0] = nv;
                    12'hB82: ins[63:32] = nv;
                    default: ;
                endcase
            end
            m_cycle = cn;
            m_instret = ins;
        end
    end

    always @(negedge clk) begin
        logic [31:0] er, ep, base;
        bit kn, ee;
        if (chk_on) begin
            er = m_read(csr_addr, kn);
            base = m_mtvec & ~32'h3;
            ee = trap_req || m_irq() || mret;
            if (trap_req)     ep = base;
            else if (m_irq()) ep = (m_mtvec[1:0] == 2'd1) ? base + 32'd28 : base;
            else              ep = m_mepc;
            chk("model_rdata", csr_rdata, er);
            chk("model_illegal", {31'b0, illegal}, {31'b0, m_illegal()});
            chk("model_redirect_en", {31'b0, redirect_en}, {31'b0, ee});
            if (ee) chk("model_redirect_pc", redirect_pc, ep);
        end
    end

    task automatic idle();
        reset = 0; csr_en = 0; csr_op = 0; csr_addr = 0; csr_wsrc = 0; src_zero = 0;
        trap_req = 0; trap_cause = 0; trap_pc = 0; mret = 0; retire = 0; next_pc = 0;
        irq_timer = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] w, input bit z);
        csr_en = 1; csr_op = o; csr_addr = a; csr_wsrc = w; src_zero = z;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        @(negedge clk);
        chk(name, csr_rdata, exp);
        nxt();
    endtask

    logic [11:0] addr_tab [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                                   12'hF12, 12'h7C0, 12'hC00, 12'h301};

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        chk_on = 1;

        csr_addr = 12'h300; @(negedge clk);
        chk("rst_mstatus", csr_rdata, 32'h1800);
        chk("rst_redirect_en", {31'b0, redirect_en}, 32'h0);
        nxt();

        op(2'd1, 12'h305, 32'h8000_0101, 0); @(negedge clk);
        chk("t1_old_mtvec", csr_rdata, C_MTVEC_RESET); nxt();
        rd("t1_new_mtvec", 12'h305, 32'h8000_0101);
        op(2'd2, 12'h300, 32'h0, 1); @(negedge clk);
        chk("t1_rs_zero_illegal", {31'b0, illegal}, 32'h0); nxt();
        rd("t1_mstatus_kept", 12'h300, 32'h1800);

        op(2'd2, 12'h300, 32'h8, 0); nxt();
        trap_req = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0010; @(negedge clk);
        chk("t2_trap_en", {31'b0, redirect_en}, 32'h1);
        chk("t2_trap_pc", redirect_pc, 32'h8000_0100); nxt();
        rd("t2_mepc", 12'h341, 32'h8000_0010);
        rd("t2_mcause", 12'h342, 32'd11);
        rd("t2_mstatus", 12'h300, 32'h1880);
        mret = 1; @(negedge clk);
        chk("t2_mret_pc", redirect_pc, 32'h8000_0010); nxt();
        rd("t2_mstatus_mret", 12'h300, 32'h1888);

        op(2'd1, 12'h304, 32'h80, 0); nxt();
        irq_timer = 1; retire = 1; next_pc = 32'h8000_0020; @(negedge clk);
        chk("t3_irq_en", {31'b0, redirect_en}, 32'h1);
        chk("t3_irq_pc", redirect_pc, 32'h8000_011C); nxt();
        rd("t3_irq_mcause", 12'h342, 32'h8000_0007);
        rd("t3_irq_mepc", 12'h341, 32'h8000_0020);
        mret = 1; nxt();
        irq_timer = 1; retire = 1; next_pc = 32'h8000_0024;
        trap_req = 1; trap_cause = 32'd2; trap_pc = 32'h8000_0030; @(negedge clk);
        chk("t3_exc_wins_pc", redirect_pc, 32'h8000_0100); nxt();
        rd("t3_exc_wins_cause", 12'h342, 32'd2);

        op(2'd1, 12'hB00, 32'hFFFF_FFFF, 0); nxt();
        rd("t4_mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        rd("t4_mcycleh_carry", 12'hB80, 32'h1);
        rd("t4_mcycle_wrapped", 12'hB00, 32'h1);
        op(2'd1, 12'hB02, 32'h0, 0); nxt();
        op(2'd1, 12'hB82, 32'h0, 0); nxt();
        repeat (3) begin retire = 1; nxt(); end
        retire = 1; trap_req = 1; trap_cause = 32'd3; trap_pc = 32'h8000_0040; nxt();
        nxt();
        rd("t4_minstret", 12'hB02, 32'd3);

        op(2'd1, 12'hF11, 32'h1, 0); @(negedge clk);
        chk("t5_ro_write_illegal", {31'b0, illegal}, 32'h1); nxt();
        op(2'd2, 12'hF11, 32'h0, 1); @(negedge clk);
        chk("t5_ro_read_legal", {31'b0, illegal}, 32'h0);
        chk("t5_mvendorid", csr_rdata, 32'h0); nxt();
        op(2'd1, 12'h7C0, 32'h5, 0); @(negedge clk);
        chk("t5_unknown_illegal", {31'b0, illegal}, 32'h1); nxt();
        op(2'd0, 12'h340, 32'h5, 0); @(negedge clk);
        chk("t5_op0_illegal", {31'b0, illegal}, 32'h1); nxt();
        op(2'd2, 12'hF12, 32'h0, 1); @(negedge clk);
        chk("t5_marchid", csr_rdata, C_MARCHID); nxt();

        op(2'd1, 12'h340, 32'hA5A5_0001, 0); nxt();
        op(2'd1, 12'h340, 32'h0000_1234, 0); trap_req = 1; trap_cause = 32'd11; nxt();
        rd("t6_mscratch_kept", 12'h340, 32'hA5A5_0001);
        reset = 1; trap_req = 1; trap_cause = 32'd5; trap_pc = 32'h1234_5678; nxt();
        rd("t6_rst_mstatus", 12'h300, 32'h1800);
        rd("t6_rst_mepc", 12'h341, 32'h0);
        rd("t6_rst_mtvec", 12'h305, C_MTVEC_RESET);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            csr_en = $urandom_range(0, 1);
            csr_op = 2'($urandom_range(0, 3));
            csr_addr = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 15)];
            src_zero = ($urandom_range(0, 3) == 0);
            csr_wsrc = src_zero ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom);
            trap_req = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom;
            trap_pc = $urandom;
            mret = ($urandom_range(0, 15) == 0);
            retire = ($urandom_range(0, 3) != 0);
            next_pc = $urandom;
            irq_timer = ($urandom_range(0, 2) == 0);
            nxt();
        end

        nxt();
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
